// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready handshakes on both sides.
// Define SEQ_DIV_SIGNED_EN to add two's-complement operation selected by is_signed_i.
module seq_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             is_signed_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   rem_sh, diff;
    logic             no_borrow;
    logic [WIDTH-1:0] step_rem, step_quo, fix_rem, fix_quo, mag_a, mag_b;
    logic             accept;

    assign accept = (state_q == StIdle) && in_valid_i;

`ifdef SEQ_DIV_SIGNED_EN
    logic neg_q_q, neg_r_q, sign_a, sign_b;

    always_comb begin
        sign_a  = is_signed_i & dividend_i[WIDTH-1];
        sign_b  = is_signed_i & divisor_i[WIDTH-1];
        mag_a   = sign_a ? -dividend_i : dividend_i;
        mag_b   = sign_b ? -divisor_i : divisor_i;
        // Remainder follows the dividend's sign: truncation toward zero.
        fix_quo = neg_q_q ? -step_quo : step_quo;
        fix_rem = neg_r_q ? -step_rem : step_rem;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= sign_a ^ sign_b;
            neg_r_q <= sign_a;
        end
    end
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed_i;
    assign mag_a            = dividend_i;
    assign mag_b            = divisor_i;
    assign fix_quo          = step_quo;
    assign fix_rem          = step_rem;
`endif

    // Invariant rem_q < dvsr_q keeps the trial difference within WIDTH+1 bits.
    always_comb begin
        rem_sh    = {rem_q, quo_q[WIDTH-1]};
        diff      = rem_sh - {1'b0, dvsr_q};
        no_borrow = ~diff[WIDTH];
        step_rem  = no_borrow ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        step_quo  = {quo_q[WIDTH-2:0], no_borrow};
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    dvsr_d = mag_b;
                    if (divisor_i == '0) begin
                        quo_d   = '1;
                        rem_d   = dividend_i;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end else begin
                        quo_d   = mag_a;
                        rem_d   = '0;
                        dbz_d   = 1'b0;
                        cnt_d   = CntW'(WIDTH);
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    quo_d   = fix_quo;
                    rem_d   = fix_rem;
                    state_d = StDone;
                end else begin
                    quo_d = step_quo;
                    rem_d = step_rem;
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready_o    = (state_q == StIdle);
    assign out_valid_o   = (state_q == StDone);
    assign quotient_o    = quo_q;
    assign remainder_o   = rem_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench: 32- and 66-bit dividers fed identical zero-extended operands,
// compared against plain / and % arithmetic, with latency, backpressure and reset checks.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset, in_valid, is_signed, out_ready;
    logic [31:0] a_drv, b_drv;
    logic [65:0] a66, b66;

    logic        rdy32, vld32, dbz32, rdy66, vld66, dbz66;
    logic [31:0] q32, r32;
    logic [65:0] q66, r66;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    assign a66 = {34'b0, a_drv};
    assign b66 = {34'b0, b_drv};

    seq_divider #(.WIDTH(32)) dut32 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(rdy32),
        .dividend_i(a_drv), .divisor_i(b_drv), .is_signed_i(is_signed),
        .out_valid_o(vld32), .out_ready_i(out_ready), .quotient_o(q32),
        .remainder_o(r32), .div_by_zero_o(dbz32)
    );

    seq_divider #(.WIDTH(66)) dut66 (
        .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(rdy66),
        .dividend_i(a66), .divisor_i(b66), .is_signed_i(is_signed),
        .out_valid_o(vld66), .out_ready_i(out_ready), .quotient_o(q66),
        .remainder_o(r66), .div_by_zero_o(dbz66)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One divide on both instances; chk66 is cleared when 66-bit results are not comparable.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                           input int hold, input logic [31:0] eq, input logic [31:0] er,
                           input logic edbz, input bit chk66);
        int          lat32, lat66;
        logic [65:0] eq66, er66;
        for (int i = 0; i < 10 && !(rdy32 && rdy66); i++) tick();
        check("in_ready_before", {rdy32, rdy66}, 2'b11);
        a_drv     = a;
        b_drv     = b;
        is_signed = sgn;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat32    = 0;
        lat66    = 0;
        for (int n = 1; n <= 200; n++) begin
            if (lat32 == 0 && vld32) lat32 = n;
            if (lat66 == 0 && vld66) lat66 = n;
            if (lat32 != 0 && lat66 != 0) break;
            tick();
        end
        check("latency32", lat32, edbz ? 1 : 33);
        check("latency66", lat66, edbz ? 1 : 67);
        repeat (hold) tick();
        eq66 = edbz ? {66{1'b1}} : {34'b0, eq};
        er66 = {34'b0, er};
        check("out_valid_held", {vld32, vld66}, 2'b11);
        check("quotient32", q32, eq);
        check("remainder32", r32, er);
        check("dbz32", dbz32, edbz);
        if (chk66) begin
            check("quotient66", q66, eq66);
            check("remainder66", r66, er66);
            check("dbz66", dbz66, edbz);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("after_consume", {rdy32, rdy66, vld32, vld66}, 4'b1100);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a, b, eq, er;
        bit          seen;

        reset     = 1'b1;
        in_valid  = 1'b0;
        is_signed = 1'b0;
        out_ready = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_ready", {rdy32, rdy66}, 2'b11);
        check("reset_valid", {vld32, vld66}, 2'b00);
        check("reset_q", {q32, q66}, '0);
        check("reset_r", {r32, r66}, '0);
        check("reset_dbz", {dbz32, dbz66}, 2'b00);

        run_div(32'd1, 32'd1, 1'b0, 0, 32'd1, 32'd0, 1'b0, 1'b1);
        run_div(32'h2537f12, 32'h7322a, 1'b0, 0, 32'h52, 32'h56d9e, 1'b0, 1'b1);
        run_div(32'h1234, 32'd0, 1'b0, 0, 32'hffff_ffff, 32'h1234, 1'b1, 1'b1);
        run_div(32'hffff_ffff, 32'd1, 1'b0, 5, 32'hffff_ffff, 32'd0, 1'b0, 1'b1);
        run_div(32'd5, 32'hffff_ffff, 1'b0, 0, 32'd0, 32'd5, 1'b0, 1'b1);

        for (int i = 0; i < 100; i++) begin
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1, 2:    b = $urandom_range(1, 255);
                3:       a = $urandom_range(0, 1000);
                default: b = $urandom;
            endcase
            if (b == 0 && i % 10 != 0) b = 32'd3;
            eq = (b == 0) ? 32'hffff_ffff : a / b;
            er = (b == 0) ? a : a % b;
            run_div(a, b, 1'b0, (i % 4 == 0) ? 5 : 0, eq, er, b == 0, 1'b1);
        end

`ifdef SEQ_DIV_SIGNED_EN
        run_div(-32'sd7, 32'sd2, 1'b1, 0, -32'sd3, -32'sd1, 1'b0, 1'b0);
        run_div(32'sd7, -32'sd2, 1'b1, 0, -32'sd3, 32'sd1, 1'b0, 1'b0);
        run_div(32'h8000_0000, 32'hffff_ffff, 1'b1, 0, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        run_div(-32'sd100, 32'd0, 1'b1, 0, 32'hffff_ffff, -32'sd100, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom_range(1, 50000);
            if (i % 2 == 1) b = -b;
            eq = $signed(a) / $signed(b);
            er = $signed(a) % $signed(b);
            run_div(a, b, 1'b1, 0, eq, er, 1'b0, 1'b0);
        end
`else
        // is_signed has no effect without the signed option.
        run_div(-32'sd7, 32'd2, 1'b1, 0, 32'h7fff_fffc, 32'd1, 1'b0, 1'b1);
`endif

        // Abort a divide with reset at T+10.
        for (int i = 0; i < 10 && !(rdy32 && rdy66); i++) tick();
        a_drv     = 32'hffff_ffff;
        b_drv     = 32'd3;
        is_signed = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check("busy_before_reset", {rdy32, rdy66}, 2'b00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", {rdy32, rdy66}, 2'b11);
        check("abort_valid", {vld32, vld66}, 2'b00);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (vld32 || vld66) seen = 1'b1;
            tick();
        end
        check("abort_no_result", seen, 1'b0);
        run_div(32'd100, 32'd7, 1'b0, 0, 32'd14, 32'd2, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Parametrised multi-cycle integer divider producing quotient and remainder for WIDTH-bit operands with a valid/ready handshake on both sides. It replaces single-cycle combinational `/` and `%` in datapaths where operand width (e.g. 66 bits) makes a one-cycle divide impractical. Operands enter through an input handshake, a radix-2 restoring iteration runs for WIDTH cycles, and the result is held until the consumer accepts it. Divide-by-zero yields a defined, flagged result instead of X.

## Interface
- WIDTH, default 32: operand, quotient and remainder width, 2..128.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present.
- in_ready  output  1  divider can accept operands.
- dividend  input  WIDTH  numerator (a).
- divisor  input  WIDTH  denominator (b).
- is_signed  input  1  treat operands as two's complement; used only when SEQ_DIV_SIGNED_EN is defined.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- quotient  output  WIDTH  a / b.
- remainder  output  WIDTH  a % b.
- div_by_zero  output  1  result came from b == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid && in_ready, latch operands. If divisor==0, go to DONE. Otherwise load iteration counter with WIDTH and go to RUN.
- RUN: in_ready=0. Each cycle performs one restoring step on the magnitudes:
  - shift {rem, quo} left by one;
  - trial-subtract divisor from rem, using a WIDTH+1-bit subtract;
  - if there is no borrow, keep the difference and set the quo LSB to 1.
  - Decrement the counter. When it reaches 0, go to DONE.
- DONE: out_valid=1. Outputs are stable until the handshake. On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no overlap and no new operands are accepted the same cycle.
- Divide-by-zero: quotient = all ones, remainder = dividend, div_by_zero=1. div_by_zero=0 for every other result.
- Unsigned arithmetic: results are exact, with remainder < divisor.
- Reset mid-operation: reset aborts any RUN or DONE operation. Return to IDLE and discard the result.
- Reset values:
  - state=IDLE, in_ready=1 from the first cycle after reset deasserts.
  - out_valid=0.
  - quotient=0, remainder=0, div_by_zero=0.

## Timing
- Accept in cycle T, with b != 0: out_valid rises at T+WIDTH+1 (WIDTH iteration cycles plus the DONE entry). Latency is fixed and independent of operand values.
- Accept in cycle T, with b == 0: out_valid rises at T+1.
- Result handshake: if out_ready is high at T+WIDTH+1, the result is consumed that cycle. in_ready rises at T+WIDTH+2.
- Throughput: one divide every WIDTH+2 cycles at best.
- Backpressure: out_valid and the outputs hold indefinitely while out_ready=0.
- in_valid while busy is ignored; the operands are not captured.

## Configuration
- SEQ_DIV_SIGNED_EN defined: when is_signed=1 at accept time, the divider works on signed operands.
  - Operands are converted to magnitudes at accept.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend, so it truncates toward zero, matching Verilog signed `/` and `%`.
  - Overflow case, dividend=most-negative and divisor=-1: quotient = most-negative, remainder = 0, div_by_zero=0.
  - Divide-by-zero gives the same result as unsigned mode.
  - Sign fix-up happens on entry to DONE, so latency is unchanged.
- SEQ_DIV_SIGNED_EN undefined: is_signed is ignored and all operations are unsigned. No sign logic is synthesised.

## Test plan
- WIDTH=32, a=1, b=1 -> at T+33: quotient=1, remainder=0, div_by_zero=0.
- WIDTH=32 and WIDTH=66, a=0x2537f12, b=0x7322a -> quotient=0x52, remainder=0x56d9e. Latency is 33 and 67 cycles respectively.
- b=0, a=0x1234 -> at T+1: quotient=all ones, remainder=0x1234, div_by_zero=1.
- 100 random unsigned pairs, instances at WIDTH=32 and WIDTH=66 with operands zero-extended:
  - results are identical across the two widths;
  - results match the `/` and `%` reference model.
  - Hold out_ready=0 for 5 cycles on some results; outputs must stay stable.
- SEQ_DIV_SIGNED_EN, WIDTH=32:
  - -7 / 2 -> quotient=-3, remainder=-1.
  - 7 / -2 -> quotient=-3, remainder=1.
  - 0x80000000 / -1 -> quotient=0x80000000, remainder=0.
- Assert reset at T+10 during RUN:
  - next cycle: in_ready=1, out_valid=0;
  - no result is ever presented for the aborted operands;
  - a fresh divide 100/7 then gives quotient=14, remainder=2.
